// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter and four-phase sequencer for the shared IO bus.
// Latches one master's request, drives the bus, decodes device select into a one-hot grant.
module io_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_DEVICES = 4,
  parameter int ADDR_W      = 32,
  parameter int CTRL_W      = 4,
  parameter int DATA_W      = 32,
  parameter int WE_BIT      = 0,
  parameter int SEL_HI      = 15,
  parameter int SEL_LO      = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*CTRL_W-1:0] m_ctrl,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic                          m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [ADDR_W-1:0]             bus_addr,
  output logic [CTRL_W-1:0]             bus_ctrl,
  output logic [DATA_W-1:0]             bus_wdata,
  output logic                          bus_wdata_oe,
  input  logic [DATA_W-1:0]             bus_rdata,
  output logic [NUM_DEVICES-1:0]        bg,
  output logic                          busy
);

  localparam int IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SelW = SEL_HI - SEL_LO + 1;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   winner_q, winner_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [NUM_MASTERS-1:0] reqRot;
  int                     pickOff;
  int                     pickIdx;
  logic [SelW-1:0]        sel;
  logic                   selOk;
  logic                   winnerReq;
  logic                   isWrite;

  // Rotate requests so bit 0 is the master after the last grant, then take the lowest set bit.
  always_comb begin
    reqRot  = NUM_MASTERS'({m_req, m_req} >> (int'(last_q) + 1));
    pickOff = 0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (reqRot[i]) pickOff = i;
    end
    pickIdx = (int'(last_q) + 1 + pickOff) % NUM_MASTERS;
  end

  assign sel       = addr_q[SEL_HI:SEL_LO];
  assign selOk     = int'(sel) < NUM_DEVICES;
  assign winnerReq = |(m_req & (NUM_MASTERS'(1) << winner_q));
  assign isWrite   = ctrl_q[WE_BIT];

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    ctrl_d   = ctrl_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (|m_req) begin
          winner_d = IdxW'(pickIdx);
          addr_d   = ADDR_W'(m_addr >> (pickIdx * ADDR_W));
          ctrl_d   = CTRL_W'(m_ctrl >> (pickIdx * CTRL_W));
          wdata_d  = DATA_W'(m_wdata >> (pickIdx * DATA_W));
          state_d  = SETUP;
        end
      end
      // A decode error still spends the XFER slot (with bg held low) so every ack has the same latency.
      SETUP: begin
        if (!winnerReq) begin
          state_d = IDLE;
        end else begin
          err_d   = !selOk;
          state_d = XFER;
        end
      end
      XFER: begin
        if (!isWrite && !err_q) rdata_d = bus_rdata;
        state_d = DONE;
      end
      DONE: begin
        last_d  = winner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      winner_q <= '0;
      last_q   <= '0;
      addr_q   <= '0;
      ctrl_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      ctrl_q   <= ctrl_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus_addr     = addr_q;
  assign bus_ctrl     = ctrl_q;
  assign bus_wdata    = wdata_q;
  assign bus_wdata_oe = (state_q == XFER) && isWrite && !err_q;
  assign bg           = ((state_q == XFER) && !err_q) ? (NUM_DEVICES'(1) << sel) : '0;
  assign m_ack        = (state_q == DONE) ? (NUM_MASTERS'(1) << winner_q) : '0;
  assign m_err        = (state_q == DONE) && err_q;
  assign m_rdata      = rdata_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed vector table, multi-cycle corner sequences,
// then randomized traffic compared against a transaction-level reference model.
module tb_io_bus_arbiter;

  localparam int NM = 2;
  localparam int ND = 4;
  localparam int AW = 32;
  localparam int CW = 4;
  localparam int DW = 32;

  logic              clk;
  logic              rst_n;
  logic [NM-1:0]     m_req;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*CW-1:0]  m_ctrl;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM-1:0]     m_ack;
  logic              m_err;
  logic [DW-1:0]     m_rdata;
  logic [AW-1:0]     bus_addr;
  logic [CW-1:0]     bus_ctrl;
  logic [DW-1:0]     bus_wdata;
  logic              bus_wdata_oe;
  logic [DW-1:0]     bus_rdata;
  logic [ND-1:0]     bg;
  logic              busy;

  int checks = 0;
  int errors = 0;

  io_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_addr(m_addr), .m_ctrl(m_ctrl),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .bus_addr(bus_addr), .bus_ctrl(bus_ctrl), .bus_wdata(bus_wdata),
    .bus_wdata_oe(bus_wdata_oe), .bus_rdata(bus_rdata), .bg(bg), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  expBg;
    logic        expOe;
    logic [1:0]  expAck;
    logic        expErr;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[6];

  // Reference model state, updated once per rising edge from the inputs the DUT sampled.
  int          cyc = 0;
  bit          inFlight = 0;
  int          mStart = 0;
  int          mWin = 0;
  int          lastGrant = 0;
  logic [31:0] mAddr = '0;
  logic [3:0]  mCtrl = '0;
  logic [31:0] mWdata = '0;
  bit          mErr = 0;
  logic [31:0] expRdata = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic setMaster(input int m, input logic [31:0] addr, input logic [3:0] ctrl,
                           input logic [31:0] wdata);
    m_addr[m*AW +: AW]  = addr;
    m_ctrl[m*CW +: CW]  = ctrl;
    m_wdata[m*DW +: DW] = wdata;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    m_req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated transfer; the master's fields are scrambled after latch to prove they are ignored.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    setMaster(v.m, v.addr, {3'b000, v.we}, v.wdata);
    bus_rdata = v.rdata;
    m_req = '0;
    m_req[v.m] = 1'b1;
    @(negedge clk);
    checkOutput("setup_busy", busy, 1);
    checkOutput("setup_bg", bg, 0);
    checkOutput("setup_addr", bus_addr, v.addr);
    setMaster(v.m, ~v.addr, 4'hF, ~v.wdata);
    @(negedge clk);
    checkOutput("xfer_bg", bg, v.expBg);
    checkOutput("xfer_oe", bus_wdata_oe, v.expOe);
    checkOutput("xfer_addr", bus_addr, v.addr);
    checkOutput("xfer_ack", m_ack, 0);
    if (v.expOe) checkOutput("xfer_wdata", bus_wdata, v.wdata);
    @(negedge clk);
    checkOutput("done_ack", m_ack, v.expAck);
    checkOutput("done_err", m_err, v.expErr);
    checkOutput("done_rdata", m_rdata, v.expRdata);
    checkOutput("done_bg", bg, 0);
    m_req = '0;
    bus_rdata = ~v.rdata;
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_ack", m_ack, 0);
  endtask

  task automatic modelStep();
    int idx;
    bit found;
    if (inFlight) begin
      if (cyc == mStart + 2 && !mErr && !mCtrl[0]) expRdata = bus_rdata;
      if (cyc == mStart + 3) begin
        inFlight  = 0;
        lastGrant = mWin;
      end
    end else if (m_req != 0) begin
      found = 0;
      for (int k = 0; k < NM; k++) begin
        idx = (lastGrant + 1 + k) % NM;
        if (!found && m_req[idx]) begin
          found = 1;
          mWin  = idx;
        end
      end
      inFlight = 1;
      mStart   = cyc;
      mAddr    = m_addr[mWin*AW +: AW];
      mCtrl    = m_ctrl[mWin*CW +: CW];
      mWdata   = m_wdata[mWin*DW +: DW];
      mErr     = (mAddr[15:12] >= 4'd4);
    end
  endtask

  task automatic modelCheck();
    int p;
    logic [3:0] eb;
    logic [1:0] ea;
    logic eo;
    p  = cyc - mStart;
    eb = (inFlight && p == 1 && !mErr) ? (4'(1) << mAddr[15:12]) : 4'd0;
    eo = inFlight && p == 1 && !mErr && mCtrl[0];
    ea = (inFlight && p == 2) ? (2'(1) << mWin) : 2'd0;
    checkOutput("rnd_busy", busy, inFlight);
    checkOutput("rnd_bg", bg, eb);
    checkOutput("rnd_oe", bus_wdata_oe, eo);
    checkOutput("rnd_ack", m_ack, ea);
    checkOutput("rnd_err", m_err, inFlight && p == 2 && mErr);
    checkOutput("rnd_rdata", m_rdata, expRdata);
    checkOutput("rnd_bg_onehot0", $onehot0(bg), 1);
    checkOutput("rnd_ack_onehot0", $onehot0(m_ack), 1);
    if (inFlight) begin
      checkOutput("rnd_addr", bus_addr, mAddr);
      checkOutput("rnd_ctrl", bus_ctrl, mCtrl);
    end
    if (eo) checkOutput("rnd_wdata", bus_wdata, mWdata);
  endtask

  task automatic newRequest(input int i);
    logic [31:0] a;
    a = $urandom();
    a[15:12] = 4'($urandom_range(0, 7));
    setMaster(i, a, 4'($urandom()), $urandom());
    m_req[i] = 1'b1;
  endtask

  task automatic driveRandom();
    for (int i = 0; i < NM; i++) begin
      if (inFlight && cyc - mStart == 2 && mWin == i) begin
        if ($urandom_range(0, 1) == 1) newRequest(i);
        else m_req[i] = 1'b0;
      end else if (!m_req[i] && $urandom_range(0, 3) == 0) begin
        newRequest(i);
      end
    end
    bus_rdata = $urandom();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int ackOrder[$];
    int ackCyc[$];
    int expOrder[4];
    int firstAck;

    rst_n = 1'b0; m_req = '0; m_addr = '0; m_ctrl = '0; m_wdata = '0; bus_rdata = '0;
    vecs[0] = '{0, 32'h0000_1004, 1'b1, 32'h0000_00A5, 32'h0,         4'b0010, 1'b1, 2'b01, 1'b0, 32'h0};
    vecs[1] = '{1, 32'h0000_2000, 1'b0, 32'h0,         32'h0000_1234, 4'b0100, 1'b0, 2'b10, 1'b0, 32'h1234};
    vecs[2] = '{0, 32'h0000_7010, 1'b0, 32'h0,         32'h0000_0BAD, 4'b0000, 1'b0, 2'b01, 1'b1, 32'h1234};
    vecs[3] = '{1, 32'hABCD_0008, 1'b1, 32'hCAFE_F00D, 32'h0000_9999, 4'b0001, 1'b1, 2'b10, 1'b0, 32'h1234};
    vecs[4] = '{0, 32'h000F_3000, 1'b0, 32'h0,         32'h0000_55AA, 4'b1000, 1'b0, 2'b01, 1'b0, 32'h55AA};
    vecs[5] = '{1, 32'h0000_4000, 1'b1, 32'h0000_0077, 32'h0,         4'b0000, 1'b0, 2'b10, 1'b1, 32'h55AA};

    resetDut();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_bg", bg, 0);
    checkOutput("reset_ack", m_ack, 0);
    checkOutput("reset_oe", bus_wdata_oe, 0);
    checkOutput("reset_addr", bus_addr, 0);
    checkOutput("reset_rdata", m_rdata, 0);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Contention from reset: pointer starts at 0 so master 1 wins first, then strict alternation.
    resetDut();
    setMaster(0, 32'h0000_0000, 4'h0, 32'h0);
    setMaster(1, 32'h0000_1000, 4'h0, 32'h0);
    m_req = 2'b11;
    expOrder = '{2, 1, 2, 1};
    for (int c = 0; c < 40 && ackOrder.size() < 4; c++) begin
      @(negedge clk);
      if (m_ack != 0) begin
        ackOrder.push_back(int'(m_ack));
        ackCyc.push_back(c);
        if (ackOrder.size() == 4) m_req = '0;
      end
    end
    m_req = '0;
    checkOutput("contention_count", ackOrder.size(), 4);
    for (int i = 0; i < ackOrder.size(); i++) begin
      checkOutput($sformatf("contention_grant%0d", i), ackOrder[i], expOrder[i]);
      if (i == 0) checkOutput("contention_first_latency", ackCyc[0], 2);
      else checkOutput($sformatf("contention_gap%0d", i), ackCyc[i] - ackCyc[i-1], 4);
    end

    // Abort in SETUP must not move the pointer: last grant was master 0, so master 1 still wins next.
    @(negedge clk);
    m_req = 2'b10;
    @(negedge clk);
    checkOutput("abort_setup_busy", busy, 1);
    m_req = 2'b00;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_bg", bg, 0);
    checkOutput("abort_ack", m_ack, 0);
    @(negedge clk);
    checkOutput("abort_ack_later", m_ack, 0);
    m_req = 2'b11;
    firstAck = 0;
    for (int c = 0; c < 10 && firstAck == 0; c++) begin
      @(negedge clk);
      if (m_ack != 0) firstAck = int'(m_ack);
    end
    m_req = '0;
    checkOutput("abort_pointer_kept", firstAck, 2);

    // Reset asserted during XFER kills the transfer without an ack.
    @(negedge clk);
    setMaster(0, 32'h0000_1004, 4'h1, 32'h0000_00A5);
    m_req = 2'b01;
    repeat (2) @(negedge clk);
    checkOutput("rstx_bg_before", bg, 4'b0010);
    checkOutput("rstx_oe_before", bus_wdata_oe, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rstx_bg", bg, 0);
    checkOutput("rstx_oe", bus_wdata_oe, 0);
    checkOutput("rstx_busy", busy, 0);
    checkOutput("rstx_ack", m_ack, 0);
    m_req = '0;
    @(negedge clk);
    checkOutput("rstx_ack_later", m_ack, 0);
    rst_n = 1'b1;

    // Randomized traffic against the transaction-level model.
    resetDut();
    for (int n = 0; n < 800; n++) begin
      @(posedge clk);
      cyc++;
      modelStep();
      @(negedge clk);
      modelCheck();
      driveRandom();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
